tag_ram_ctrl: RTL

Lookup/allocate controller for the synchronous-read cache tag RAM (8 sets × 14-bit entries) used by the write-hit check path. It accepts one read or write request at a time and sequences the tag RAM address, read and write ports. It compares the stored tag, updates valid/dirty bits, and reports hit, miss and dirty-victim status. It also clears every tag entry after reset and on flush.

---
 rtl/tag_ctrl_pkg.sv | 29 ++
 rtl/tag_entry_cmp.sv | 39 +++
 rtl/tag_ram_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tag_ctrl_pkg.sv
// Shared types, entry layout and request-address slicing for the tag RAM controller.
package tag_ctrl_pkg;

    localparam int AWIDTH    = 3;
    localparam int DWIDTH    = 14;
    localparam int OFF_W     = 2;
    localparam int DEPTH     = 1 << AWIDTH;
    localparam int TAG_W     = DWIDTH - 2;
    localparam int RA_W      = TAG_W + AWIDTH + OFF_W;
    localparam int VALID_BIT = DWIDTH - 1;
    localparam int DIRTY_BIT = DWIDTH - 2;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_COMPARE,
        ST_RESP
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [RA_W-1:0] addr);
        return addr[RA_W-1:AWIDTH+OFF_W];
    endfunction

    function automatic logic [AWIDTH-1:0] addr_index(input logic [RA_W-1:0] addr);
        return addr[AWIDTH+OFF_W-1:OFF_W];
    endfunction

endpackage

// File: rtl/tag_entry_cmp.sv
// Combinational tag compare: decides hit, the replacement/update entry and victim status.
module tag_entry_cmp
    import tag_ctrl_pkg::*;
(
    input  logic [DWIDTH-1:0] old_entry,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic              req_we,
    output logic              hit,
    output logic              need_write,
    output logic [DWIDTH-1:0] new_entry,
    output logic              evict,
    output logic [TAG_W-1:0]  victim_tag
);

    logic old_valid;
    logic old_dirty;

    assign old_valid = old_entry[VALID_BIT];
    assign old_dirty = old_entry[DIRTY_BIT];

    always_comb begin
        hit        = old_valid && (old_entry[TAG_W-1:0] == req_tag);
        need_write = 1'b0;
        new_entry  = '0;
        evict      = 1'b0;
        victim_tag = '0;
        if (hit) begin
            // a clean line only needs rewriting when a write marks it dirty
            need_write = req_we && !old_dirty;
            new_entry  = {1'b1, 1'b1, req_tag};
        end else begin
            need_write = 1'b1;
            new_entry  = {1'b1, req_we, req_tag};
            evict      = old_valid && old_dirty;
            victim_tag = old_entry[TAG_W-1:0];
        end
    end

endmodule

// File: rtl/tag_ram_ctrl.sv
// Lookup/allocate sequencer for the synchronous-read cache tag RAM, with clear sweep on reset and flush.
//   state      | meaning
//   ST_INIT    | clear sweep, writes zero to every set
//   ST_IDLE    | ready for a request or a flush
//   ST_LOOKUP  | tag RAM read address presented
//   ST_COMPARE | read data valid, compare and optional update write
//   ST_RESP    | one-cycle response pulse
module tag_ram_ctrl
    import tag_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [RA_W-1:0]   req_addr,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              resp_evict,
    output logic [TAG_W-1:0]  resp_victim_tag,
    output logic              busy,
    output logic [AWIDTH-1:0] tr_addr,
    output logic              tr_we,
    output logic [DWIDTH-1:0] tr_din,
    input  logic [DWIDTH-1:0] tr_dout
);

    state_t state, state_nxt;

    logic [AWIDTH-1:0] sweep_cnt;
    logic [AWIDTH-1:0] req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              req_we_q;
    logic              accept;
    logic              we_raw;
    logic [DWIDTH-1:0] din_raw;

    logic              cmp_hit;
    logic              cmp_need_write;
    logic [DWIDTH-1:0] cmp_new_entry;
    logic              cmp_evict;
    logic [TAG_W-1:0]  cmp_victim_tag;

    assign req_ready = (state == ST_IDLE) && !flush && reset_n;
    assign accept    = req_valid && req_ready;

    tag_entry_cmp u_cmp (
        .old_entry  (tr_dout),
        .req_tag    (req_tag),
        .req_we     (req_we_q),
        .hit        (cmp_hit),
        .need_write (cmp_need_write),
        .new_entry  (cmp_new_entry),
        .evict      (cmp_evict),
        .victim_tag (cmp_victim_tag)
    );

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        tr_addr   = '0;
        we_raw    = 1'b0;
        din_raw   = '0;
        case (state)
            ST_INIT: begin
                busy    = 1'b1;
                we_raw  = 1'b1;
                tr_addr = sweep_cnt;
                if (sweep_cnt == AWIDTH'(DEPTH - 1)) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (flush)       state_nxt = ST_INIT;
                else if (accept) state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                tr_addr   = req_idx;
                state_nxt = ST_COMPARE;
            end
            ST_COMPARE: begin
                tr_addr   = req_idx;
                we_raw    = cmp_need_write;
                din_raw   = cmp_new_entry;
                state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_INIT;
        endcase
    end

    // reset gates the write strobe immediately so a half-finished update never lands
    assign tr_we  = we_raw && reset_n;
    assign tr_din = tr_we ? din_raw : '0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state           <= ST_INIT;
            sweep_cnt       <= '0;
            req_idx         <= '0;
            req_tag         <= '0;
            req_we_q        <= 1'b0;
            resp_valid      <= 1'b0;
            resp_hit        <= 1'b0;
            resp_evict      <= 1'b0;
            resp_victim_tag <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT)                 sweep_cnt <= sweep_cnt + 1'b1;
            else if (state == ST_IDLE && flush)   sweep_cnt <= '0;
            if (accept) begin
                req_we_q <= req_we;
                req_tag  <= addr_tag(req_addr);
                req_idx  <= addr_index(req_addr);
            end
            resp_valid <= (state == ST_COMPARE);
            if (state == ST_COMPARE) begin
                resp_hit        <= cmp_hit;
                resp_evict      <= cmp_evict;
                resp_victim_tag <= cmp_victim_tag;
            end
        end
    end

endmodule
